// File: rtl/rc5_key_mixer_param.sv
// RC5 key-schedule mixer: 3*max(T,C) mixing steps over external S/L RAMs, 4 cycles per step.
// Start is accepted in IDLE/DONE; abort returns to IDLE without a further write; oDone is sticky.
module rc5_key_mixer_param #(
    parameter int W = 32,
    parameter int C = 4,
    parameter int T = 26,
    localparam int TW = (T > 1) ? $clog2(T) : 1,
    localparam int CW = (C > 1) ? $clog2(C) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iStart,
    input  logic          iAbort,
    output logic          oBusy,
    output logic          oDone,
    output logic [TW-1:0] oS_addr,
    input  logic [W-1:0]  iS_rdata,
    output logic [W-1:0]  oS_wdata,
    output logic          oS_we,
    output logic [CW-1:0] oL_addr,
    input  logic [W-1:0]  iL_rdata,
    output logic [W-1:0]  oL_wdata,
    output logic          oL_we
);
    localparam int RW = $clog2(W);
    localparam int N  = 3 * ((T > C) ? T : C);
    localparam int NW = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, ADDR, READ, MIX, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  s_rd_q, s_rd_d, l_rd_q, l_rd_d;
    logic [W-1:0]  s_wdata_q, s_wdata_d, l_wdata_q, l_wdata_d;
    logic [TW-1:0] i_q, i_d, i_nxt;
    logic [CW-1:0] j_q, j_d, j_nxt;
    logic [NW-1:0] cnt_q, cnt_d, cnt_nxt;
    logic          we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [W-1:0]  s_mix, sb_sum, l_mix;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    assign s_mix  = rotl(s_rd_q + a_q + b_q, RW'(3));
    assign sb_sum = s_mix + b_q;
    assign l_mix  = rotl(l_rd_q + sb_sum, sb_sum[RW-1:0]);

    // T and C need not be powers of two, so wrap by comparison.
    assign i_nxt   = (i_q == TW'(T - 1)) ? '0 : i_q + TW'(1);
    assign j_nxt   = (j_q == CW'(C - 1)) ? '0 : j_q + CW'(1);
    assign cnt_nxt = cnt_q + NW'(1);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        s_rd_d    = s_rd_q;
        l_rd_d    = l_rd_q;
        s_wdata_d = s_wdata_q;
        l_wdata_d = l_wdata_q;
        i_d       = i_q;
        j_d       = j_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (iStart && !iAbort) begin
                    state_d = ADDR;
                    a_d     = '0;
                    b_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ADDR: state_d = READ;
            READ: begin
                s_rd_d  = iS_rdata;
                l_rd_d  = iL_rdata;
                state_d = MIX;
            end
            MIX: begin
                s_wdata_d = s_mix;
                l_wdata_d = l_mix;
                we_d      = 1'b1;
                state_d   = WRITE;
            end
            WRITE: begin
                a_d   = s_wdata_q;
                b_d   = l_wdata_q;
                i_d   = i_nxt;
                j_d   = j_nxt;
                cnt_d = cnt_nxt;
                if (cnt_nxt == NW'(N)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
        if (iAbort && busy_q) begin
            state_d = IDLE;
            we_d    = 1'b0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            s_rd_q    <= '0;
            l_rd_q    <= '0;
            s_wdata_q <= '0;
            l_wdata_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_rd_q    <= s_rd_d;
            l_rd_q    <= l_rd_d;
            s_wdata_q <= s_wdata_d;
            l_wdata_q <= l_wdata_d;
            i_q       <= i_d;
            j_q       <= j_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oS_addr  = i_q;
    assign oL_addr  = j_q;
    assign oS_wdata = s_wdata_q;
    assign oL_wdata = l_wdata_q;
    // An abort landing in the WRITE cycle must suppress the pending RAM write.
    assign oS_we    = we_q & ~iAbort;
    assign oL_we    = we_q & ~iAbort;

endmodule

// File: tb/tb_rc5_key_mixer_param.sv
// Bench for rc5_key_mixer_param: three parameter sets on one clock/reset, each with synchronous
// S/L RAM models; results compared with hand vectors and a reference RC5 key-schedule loop.
module tb_rc5_key_mixer_param;
    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;
    localparam logic [15:0] P16 = 16'hB7E1;
    localparam logic [15:0] Q16 = 16'h9E37;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0] sel = 2'd0;
    logic       go = 1'b0, abt = 1'b0, init = 1'b0;

    // Instance A: W=32 T=26 C=4
    logic        a_start, a_abort, a_busy, a_done, a_s_we, a_l_we;
    logic [4:0]  a_s_addr;
    logic [1:0]  a_l_addr;
    logic [31:0] a_s_rdata, a_s_wdata, a_l_rdata, a_l_wdata;
    logic [31:0] a_smem [32], a_lmem [4], a_sinit [32], a_linit [4];
    // Instance B: W=32 T=4 C=8
    logic        b_start, b_abort, b_busy, b_done, b_s_we, b_l_we;
    logic [1:0]  b_s_addr;
    logic [2:0]  b_l_addr;
    logic [31:0] b_s_rdata, b_s_wdata, b_l_rdata, b_l_wdata;
    logic [31:0] b_smem [4], b_lmem [8], b_sinit [4], b_linit [8];
    // Instance C: W=16 T=18 C=2
    logic        c_start, c_abort, c_busy, c_done, c_s_we, c_l_we;
    logic [4:0]  c_s_addr;
    logic [0:0]  c_l_addr;
    logic [15:0] c_s_rdata, c_s_wdata, c_l_rdata, c_l_wdata;
    logic [15:0] c_smem [32], c_lmem [2], c_sinit [32], c_linit [2];

    assign a_start = go  && (sel == 2'd0);
    assign b_start = go  && (sel == 2'd1);
    assign c_start = go  && (sel == 2'd2);
    assign a_abort = abt && (sel == 2'd0);
    assign b_abort = abt && (sel == 2'd1);
    assign c_abort = abt && (sel == 2'd2);

    rc5_key_mixer_param #(.W(32), .C(4), .T(26)) u_a (
        .clk(clk), .rst(rst), .iStart(a_start), .iAbort(a_abort), .oBusy(a_busy), .oDone(a_done),
        .oS_addr(a_s_addr), .iS_rdata(a_s_rdata), .oS_wdata(a_s_wdata), .oS_we(a_s_we),
        .oL_addr(a_l_addr), .iL_rdata(a_l_rdata), .oL_wdata(a_l_wdata), .oL_we(a_l_we));
    rc5_key_mixer_param #(.W(32), .C(8), .T(4)) u_b (
        .clk(clk), .rst(rst), .iStart(b_start), .iAbort(b_abort), .oBusy(b_busy), .oDone(b_done),
        .oS_addr(b_s_addr), .iS_rdata(b_s_rdata), .oS_wdata(b_s_wdata), .oS_we(b_s_we),
        .oL_addr(b_l_addr), .iL_rdata(b_l_rdata), .oL_wdata(b_l_wdata), .oL_we(b_l_we));
    rc5_key_mixer_param #(.W(16), .C(2), .T(18)) u_c (
        .clk(clk), .rst(rst), .iStart(c_start), .iAbort(c_abort), .oBusy(c_busy), .oDone(c_done),
        .oS_addr(c_s_addr), .iS_rdata(c_s_rdata), .oS_wdata(c_s_wdata), .oS_we(c_s_we),
        .oL_addr(c_l_addr), .iL_rdata(c_l_rdata), .oL_wdata(c_l_wdata), .oL_we(c_l_we));

    always @(posedge clk) begin
        if (init && sel == 2'd0) begin
            for (int k = 0; k < 32; k++) a_smem[k] <= a_sinit[k];
            for (int k = 0; k < 4; k++) a_lmem[k] <= a_linit[k];
        end else begin
            a_s_rdata <= a_smem[a_s_addr];
            a_l_rdata <= a_lmem[a_l_addr];
            if (a_s_we) a_smem[a_s_addr] <= a_s_wdata;
            if (a_l_we) a_lmem[a_l_addr] <= a_l_wdata;
        end
    end
    always @(posedge clk) begin
        if (init && sel == 2'd1) begin
            for (int k = 0; k < 4; k++) b_smem[k] <= b_sinit[k];
            for (int k = 0; k < 8; k++) b_lmem[k] <= b_linit[k];
        end else begin
            b_s_rdata <= b_smem[b_s_addr];
            b_l_rdata <= b_lmem[b_l_addr];
            if (b_s_we) b_smem[b_s_addr] <= b_s_wdata;
            if (b_l_we) b_lmem[b_l_addr] <= b_l_wdata;
        end
    end
    always @(posedge clk) begin
        if (init && sel == 2'd2) begin
            for (int k = 0; k < 32; k++) c_smem[k] <= c_sinit[k];
            for (int k = 0; k < 2; k++) c_lmem[k] <= c_linit[k];
        end else begin
            c_s_rdata <= c_smem[c_s_addr];
            c_l_rdata <= c_lmem[c_l_addr];
            if (c_s_we) c_smem[c_s_addr] <= c_s_wdata;
            if (c_l_we) c_lmem[c_l_addr] <= c_l_wdata;
        end
    end

    logic        obs_busy, obs_done, obs_s_we, obs_l_we;
    logic [7:0]  obs_s_addr, obs_l_addr;
    logic [31:0] obs_s_wdata, obs_l_wdata;
    always_comb begin
        obs_busy = a_busy; obs_done = a_done; obs_s_we = a_s_we; obs_l_we = a_l_we;
        obs_s_addr = 8'(a_s_addr); obs_l_addr = 8'(a_l_addr);
        obs_s_wdata = a_s_wdata; obs_l_wdata = a_l_wdata;
        if (sel == 2'd1) begin
            obs_busy = b_busy; obs_done = b_done; obs_s_we = b_s_we; obs_l_we = b_l_we;
            obs_s_addr = 8'(b_s_addr); obs_l_addr = 8'(b_l_addr);
            obs_s_wdata = b_s_wdata; obs_l_wdata = b_l_wdata;
        end else if (sel == 2'd2) begin
            obs_busy = c_busy; obs_done = c_done; obs_s_we = c_s_we; obs_l_we = c_l_we;
            obs_s_addr = 8'(c_s_addr); obs_l_addr = 8'(c_l_addr);
            obs_s_wdata = 32'(c_s_wdata); obs_l_wdata = 32'(c_l_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference RC5 key schedule on ms/ml (values held in the low w bits).
    logic [31:0] ms [256], ml [256];

    function automatic logic [31:0] mrotl(input logic [31:0] x, input int n, input int w);
        logic [63:0] v;
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        n = n % w;
        v = {32'h0, x & m};
        if (n != 0) v = (v << n) | (v >> (w - n));
        return v[31:0] & m;
    endfunction

    task automatic model(input int w, input int t, input int c);
        logic [31:0] m, a, b;
        int i, j, n;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a = 0; b = 0; i = 0; j = 0;
        n = 3 * ((t > c) ? t : c);
        for (int k = 0; k < n; k++) begin
            ms[i] = mrotl((ms[i] + a + b) & m, 3, w);
            a = ms[i];
            ml[j] = mrotl((ml[j] + a + b) & m, int'((a + b) & 32'(w - 1)), w);
            b = ml[j];
            i = (i + 1) % t;
            j = (j + 1) % c;
        end
    endtask

    task automatic load();
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
    endtask

    // Starts the selected instance and samples each cycle until done or sample index 'limit'.
    task automatic run(input string tag, input int et, input int ec, input int glitch_at,
                       input int limit, output int done_c, output int nws, output int nwl,
                       output int first_c, output logic [31:0] first_s, output logic [31:0] first_l);
        int c;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        c = 0; done_c = -1; nws = 0; nwl = 0; first_c = -1; first_s = 0; first_l = 0;
        check({tag, "_busy_at_start"}, 64'(obs_busy), 64'd1);
        check({tag, "_done_at_start"}, 64'(obs_done), 64'd0);
        forever begin
            if (obs_done) begin
                done_c = c;
                break;
            end
            if (obs_s_we) begin
                if (first_c < 0) begin
                    first_c = c; first_s = obs_s_wdata; first_l = obs_l_wdata;
                end
                check({tag, "_s_addr"}, 64'(obs_s_addr), 64'(nws % et));
                nws++;
            end
            if (obs_l_we) begin
                check({tag, "_l_addr"}, 64'(obs_l_addr), 64'(nwl % ec));
                nwl++;
            end
            if (c == glitch_at) go = 1'b1;
            if (c == glitch_at + 1) go = 1'b0;
            if (c == limit) break;
            @(negedge clk);
            c++;
        end
    endtask

    int dc, nws, nwl, fc, wr;
    logic [31:0] fs, fl;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(obs_busy), 64'd0);
        check("rst_done", 64'(obs_done), 64'd0);
        check("rst_s_addr", 64'(obs_s_addr), 64'd0);
        check("rst_l_addr", 64'(obs_l_addr), 64'd0);
        check("rst_s_wdata", 64'(obs_s_wdata), 64'd0);
        check("rst_l_wdata", 64'(obs_l_wdata), 64'd0);
        check("rst_we", 64'({obs_s_we, obs_l_we}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // W=32 T=26 C=4, S from P/Q, L zero; iStart glitched mid-run
        sel = 2'd0;
        for (int k = 0; k < 32; k++) a_sinit[k] = P32 + 32'(k) * Q32;
        for (int k = 0; k < 4; k++) a_linit[k] = 32'h0;
        load();
        for (int k = 0; k < 26; k++) ms[k] = a_sinit[k];
        for (int k = 0; k < 4; k++) ml[k] = 32'h0;
        model(32, 26, 4);
        run("A", 26, 4, 40, 400, dc, nws, nwl, fc, fs, fl);
        check("A_first_cycle", 64'(fc), 64'd3);
        check("A_first_S", 64'(fs), 64'hBF0A8B1D);
        check("A_first_L", 64'(fl), 64'hB7E15163);
        check("A_done_cycle", 64'(dc), 64'd312);
        check("A_nws", 64'(nws), 64'd78);
        check("A_nwl", 64'(nwl), 64'd78);
        check("A_busy_in_done", 64'(obs_busy), 64'd0);
        for (int k = 0; k < 26; k++) check($sformatf("A_S%0d", k), 64'(a_smem[k]), 64'(ms[k]));
        for (int k = 0; k < 4; k++) check($sformatf("A_L%0d", k), 64'(a_lmem[k]), 64'(ml[k]));

        // Restart from DONE over the already-mixed tables
        model(32, 26, 4);
        run("A2", 26, 4, -5, 400, dc, nws, nwl, fc, fs, fl);
        check("A2_done_cycle", 64'(dc), 64'd312);
        for (int k = 0; k < 26; k++) check($sformatf("A2_S%0d", k), 64'(a_smem[k]), 64'(ms[k]));

        // W=32 T=4 C=8: C exceeds T
        sel = 2'd1;
        for (int k = 0; k < 4; k++) b_sinit[k] = P32 + 32'(k) * Q32;
        for (int k = 0; k < 8; k++) b_linit[k] = 32'h13579BDF + 32'(k) * 32'h01010101;
        load();
        for (int k = 0; k < 4; k++) ms[k] = b_sinit[k];
        for (int k = 0; k < 8; k++) ml[k] = b_linit[k];
        model(32, 4, 8);
        run("B", 4, 8, -5, 200, dc, nws, nwl, fc, fs, fl);
        check("B_done_cycle", 64'(dc), 64'd96);
        check("B_nws", 64'(nws), 64'd24);
        check("B_nwl", 64'(nwl), 64'd24);
        for (int k = 0; k < 4; k++) check($sformatf("B_S%0d", k), 64'(b_smem[k]), 64'(ms[k]));
        for (int k = 0; k < 8; k++) check($sformatf("B_L%0d", k), 64'(b_lmem[k]), 64'(ml[k]));

        // W=16 T=18 C=2: S[0]=0x6002 makes the first S'+B = 0x0013
        sel = 2'd2;
        for (int k = 0; k < 32; k++) c_sinit[k] = P16 + 16'(k) * Q16;
        c_sinit[0] = 16'h6002;
        c_linit[0] = 16'h1000;
        c_linit[1] = 16'h5A5A;
        load();
        for (int k = 0; k < 18; k++) ms[k] = 32'(c_sinit[k]);
        for (int k = 0; k < 2; k++) ml[k] = 32'(c_linit[k]);
        model(16, 18, 2);
        run("C", 18, 2, -5, 300, dc, nws, nwl, fc, fs, fl);
        check("C_first_S", 64'(fs), 64'h0013);
        check("C_first_L", 64'(fl), 64'h8098);
        check("C_done_cycle", 64'(dc), 64'd216);
        for (int k = 0; k < 18; k++) check($sformatf("C_S%0d", k), 64'(c_smem[k]), 64'(ms[k]));
        for (int k = 0; k < 2; k++) check($sformatf("C_L%0d", k), 64'(c_lmem[k]), 64'(ml[k]));

        // Abort during the MIX cycle of the fifth iteration
        sel = 2'd0;
        load();
        run("AB", 26, 4, -5, 18, dc, nws, nwl, fc, fs, fl);
        check("AB_writes_before", 64'(nws), 64'd4);
        abt = 1'b1;
        @(negedge clk);
        abt = 1'b0;
        check("AB_we", 64'({obs_s_we, obs_l_we}), 64'd0);
        check("AB_busy", 64'(obs_busy), 64'd0);
        check("AB_done", 64'(obs_done), 64'd0);
        wr = 0;
        repeat (20) begin
            @(negedge clk);
            if (obs_s_we || obs_l_we) wr++;
        end
        check("AB_no_writes", 64'(wr), 64'd0);
        check("AB_done_after", 64'(obs_done), 64'd0);
        load();
        for (int k = 0; k < 26; k++) ms[k] = a_sinit[k];
        for (int k = 0; k < 4; k++) ml[k] = 32'h0;
        model(32, 26, 4);
        run("AR", 26, 4, -5, 400, dc, nws, nwl, fc, fs, fl);
        check("AR_done_cycle", 64'(dc), 64'd312);
        for (int k = 0; k < 26; k++) check($sformatf("AR_S%0d", k), 64'(a_smem[k]), 64'(ms[k]));
        for (int k = 0; k < 4; k++) check($sformatf("AR_L%0d", k), 64'(a_lmem[k]), 64'(ml[k]));

        // Asynchronous reset in the READ cycle of the third iteration
        run("RS", 26, 4, -5, 9, dc, nws, nwl, fc, fs, fl);
        check("RS_addr_before", 64'(obs_s_addr), 64'd2);
        rst = 1'b1;
        #1;
        check("RS_busy", 64'(obs_busy), 64'd0);
        check("RS_done", 64'(obs_done), 64'd0);
        check("RS_s_addr", 64'(obs_s_addr), 64'd0);
        check("RS_l_addr", 64'(obs_l_addr), 64'd0);
        check("RS_s_wdata", 64'(obs_s_wdata), 64'd0);
        check("RS_l_wdata", 64'(obs_l_wdata), 64'd0);
        check("RS_we", 64'({obs_s_we, obs_l_we}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr = 0;
        repeat (20) begin
            @(negedge clk);
            if (obs_s_we || obs_l_we) wr++;
        end
        check("RS_no_writes", 64'(wr), 64'd0);
        check("RS_busy_after", 64'(obs_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
